// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, address-mux selects, request kinds.
// Also holds the registered port-control bundle and the wait-counter width helper.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        WR      = 2'b10,
        DONE    = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        K_IF = 2'b00,
        K_LD = 2'b01,
        K_ST = 2'b10
    } kind_t;

    localparam logic IORD_PC  = 1'b0;
    localparam logic IORD_ALU = 1'b1;

    typedef struct packed {
        logic iord;
        logic mem_w;
        logic ir_w;
        logic pc_adv_w;
        logic mdr_w;
        logic if_done;
        logic ld_done;
        logic st_done;
        logic busy;
    } port_ctl_t;

    function automatic int cnt_width(input int rd_lat, input int wr_lat);
        return $clog2(((rd_lat > wr_lat) ? rd_lat : wr_lat) + 1);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-state counter: clear wins over enable; hit is a combinational equality against the target.
// Registered count, no backpressure; the arbiter stops enabling once hit is seen.
module wait_counter
    import cpu_mem_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_target,
    output logic         o_hit
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_hit = (r_count == i_target);

    // Equality-only compare: stepping past all-ones would alias a small count.
    property p_no_wrap;
        @(posedge i_clk) disable iff (i_rst) !(i_enable && !i_clear && (&r_count));
    endproperty
    a_no_wrap: assert property (p_no_wrap);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch/load/store onto the single memory port and inserts wait states (store > load > fetch).
// Reads take READ_LAT cycles, stores WRITE_LAT, plus one done cycle; requesters hold req until done.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int READ_LAT  = 3,
    parameter int WRITE_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic ld_req,
    input  logic st_req,
    output logic iord,
    output logic mem_w,
    output logic ir_w,
    output logic pc_adv_w,
    output logic mdr_w,
    output logic if_done,
    output logic ld_done,
    output logic st_done,
    output logic busy
);

    localparam int CW = cnt_width(READ_LAT, WRITE_LAT);

    state_t        r_state, w_next_state;
    kind_t         r_kind, w_next_kind;
    port_ctl_t     r_out, w_out;
    logic          w_hit;
    logic          w_cnt_clear;
    logic          w_cnt_en;
    logic          w_any_req;
    logic [CW-1:0] w_target;

    assign w_any_req   = if_req | ld_req | st_req;
    assign w_target    = (r_kind == K_ST) ? CW'(WRITE_LAT) : CW'(READ_LAT);
    assign w_cnt_clear = (r_state == DONE);
    // Acceptance loads count 1; waiting states step until the target is reached.
    assign w_cnt_en    = ((r_state == IDLE) && w_any_req) ||
                         (((r_state == RD_WAIT) || (r_state == WR)) && !w_hit);

    wait_counter #(.W(CW)) u_wait_counter (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .i_target (w_target),
        .o_hit    (w_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_kind  <= K_IF;
        end else begin
            r_state <= w_next_state;
            r_kind  <= w_next_kind;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_kind  = r_kind;
        case (r_state)
            IDLE: begin
                if (st_req) begin
                    w_next_state = WR;
                    w_next_kind  = K_ST;
                end else if (ld_req) begin
                    w_next_state = RD_WAIT;
                    w_next_kind  = K_LD;
                end else if (if_req) begin
                    w_next_state = RD_WAIT;
                    w_next_kind  = K_IF;
                end
            end
            RD_WAIT, WR: begin
                if (w_hit) w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every control lands registered on the edge.
    always_comb begin
        w_out      = '0;
        w_out.iord = IORD_PC;
        case (w_next_state)
            RD_WAIT: w_out.iord = (w_next_kind == K_LD) ? IORD_ALU : IORD_PC;
            WR: begin
                w_out.iord  = IORD_ALU;
                w_out.mem_w = 1'b1;
            end
            DONE: begin
                w_out.iord     = (w_next_kind == K_IF) ? IORD_PC : IORD_ALU;
                w_out.ir_w     = (w_next_kind == K_IF);
                w_out.pc_adv_w = (w_next_kind == K_IF);
                w_out.if_done  = (w_next_kind == K_IF);
                w_out.mdr_w    = (w_next_kind == K_LD);
                w_out.ld_done  = (w_next_kind == K_LD);
                w_out.st_done  = (w_next_kind == K_ST);
            end
            default: ;
        endcase
        w_out.busy = (w_next_state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_out <= '0;
        else       r_out <= w_out;
    end

    assign iord     = r_out.iord;
    assign mem_w    = r_out.mem_w;
    assign ir_w     = r_out.ir_w;
    assign pc_adv_w = r_out.pc_adv_w;
    assign mdr_w    = r_out.mdr_w;
    assign if_done  = r_out.if_done;
    assign ld_done  = r_out.ld_done;
    assign st_done  = r_out.st_done;
    assign busy     = r_out.busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances with different latencies, directed table,
// corner-case sequences and randomized requesters against a transaction-schedule model.
module tb_mem_port_arbiter;

    localparam int ND = 3;

    function automatic int rl_of(input int g);
        case (g)
            0:       return 3;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    function automatic int wl_of(input int g);
        case (g)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [ND-1:0] if_req = '0;
    logic [ND-1:0] ld_req = '0;
    logic [ND-1:0] st_req = '0;
    logic [ND-1:0] iord, mem_w, ir_w, pc_adv_w, mdr_w, if_done, ld_done, st_done, busy;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mem_port_arbiter #(.READ_LAT(rl_of(g)), .WRITE_LAT(wl_of(g))) u_dut (
            .clk      (clk),
            .reset    (rst),
            .if_req   (if_req[g]),
            .ld_req   (ld_req[g]),
            .st_req   (st_req[g]),
            .iord     (iord[g]),
            .mem_w    (mem_w[g]),
            .ir_w     (ir_w[g]),
            .pc_adv_w (pc_adv_w[g]),
            .mdr_w    (mdr_w[g]),
            .if_done  (if_done[g]),
            .ld_done  (ld_done[g]),
            .st_done  (st_done[g]),
            .busy     (busy[g])
        );
    end

    // Output vector order: {iord, mem_w, ir_w, pc_adv_w, mdr_w, if_done, ld_done, st_done, busy}
    function automatic logic [8:0] get_out(input int g);
        return {iord[g], mem_w[g], ir_w[g], pc_adv_w[g], mdr_w[g],
                if_done[g], ld_done[g], st_done[g], busy[g]};
    endfunction

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    // Model: on acceptance, the whole expected output schedule of the transaction is laid out.
    logic [8:0] sched [ND][0:15];
    int         slen [ND];
    int         spos [ND];
    logic [8:0] m_exp [ND];

    task automatic model_edge(input int g, output logic [8:0] e);
        int k;
        int lat;
        if (spos[g] >= slen[g]) begin
            slen[g] = 0;
            spos[g] = 0;
            k = st_req[g] ? 2 : ld_req[g] ? 1 : if_req[g] ? 0 : -1;
            if (k >= 0) begin
                lat = (k == 2) ? wl_of(g) : rl_of(g);
                for (int i = 0; i < lat; i++) sched[g][i] = {k != 0, k == 2, 6'b0, 1'b1};
                sched[g][lat]     = {k != 0, 1'b0, k == 0, k == 0, k == 1, k == 0, k == 1, k == 2, 1'b1};
                sched[g][lat + 1] = '0;
                slen[g] = lat + 2;
            end
        end
        e = (spos[g] < slen[g]) ? sched[g][spos[g]] : 9'd0;
        if (spos[g] < slen[g]) spos[g]++;
    endtask

    task automatic drive_req(input int g, input logic [8:0] e);
        if (e[3]) if_req[g] = 1'b0;
        else if (!if_req[g] && $urandom_range(3) == 0) if_req[g] = 1'b1;
        if (e[2]) ld_req[g] = 1'b0;
        else if (!ld_req[g] && $urandom_range(3) == 0) ld_req[g] = 1'b1;
        if (e[1]) st_req[g] = 1'b0;
        else if (!st_req[g] && $urandom_range(5) == 0) st_req[g] = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        if_req = '0;
        ld_req = '0;
        st_req = '0;
        for (int g = 0; g < ND; g++) begin
            slen[g] = 0;
            spos[g] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [2:0] req;    // {st, ld, if}
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [14:0] got_mask;
        logic [14:0] exp_mask;
        int          n_irw;
        int          n_st;
        int          lat;

        // Instance 0: READ_LAT=3, WRITE_LAT=1
        tbl.push_back('{3'b001, 9'b000000001});
        tbl.push_back('{3'b001, 9'b000000001});
        tbl.push_back('{3'b001, 9'b000000001});
        tbl.push_back('{3'b001, 9'b001101001});
        tbl.push_back('{3'b000, 9'b000000000});
        tbl.push_back('{3'b000, 9'b000000000});
        tbl.push_back('{3'b101, 9'b110000001});
        tbl.push_back('{3'b101, 9'b100000011});
        tbl.push_back('{3'b001, 9'b000000000});
        tbl.push_back('{3'b001, 9'b000000001});
        tbl.push_back('{3'b001, 9'b000000001});
        tbl.push_back('{3'b001, 9'b000000001});
        tbl.push_back('{3'b001, 9'b001101001});
        tbl.push_back('{3'b000, 9'b000000000});
        tbl.push_back('{3'b010, 9'b100000001});
        tbl.push_back('{3'b010, 9'b100000001});
        tbl.push_back('{3'b010, 9'b100000001});
        tbl.push_back('{3'b010, 9'b100010101});
        tbl.push_back('{3'b000, 9'b000000000});
        tbl.push_back('{3'b011, 9'b100000001});
        tbl.push_back('{3'b011, 9'b100000001});
        tbl.push_back('{3'b011, 9'b100000001});
        tbl.push_back('{3'b011, 9'b100010101});
        tbl.push_back('{3'b001, 9'b000000000});
        tbl.push_back('{3'b001, 9'b000000001});
        tbl.push_back('{3'b001, 9'b000000001});
        tbl.push_back('{3'b001, 9'b000000001});
        tbl.push_back('{3'b001, 9'b001101001});
        tbl.push_back('{3'b000, 9'b000000000});

        do_reset();
        for (int g = 0; g < ND; g++) check($sformatf("reset_dut%0d", g), get_out(g), 9'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            {st_req[0], ld_req[0], if_req[0]} = tbl[i].req;
            step();
            check($sformatf("tbl_row%0d", i), get_out(0), tbl[i].exp);
        end

        // Asynchronous reset in the middle of a WRITE_LAT=3 store.
        do_reset();
        st_req[1] = 1'b1;
        step();
        check("rst_st_edge0", get_out(1), 9'b110000001);
        step();
        check("rst_st_edge1", get_out(1), 9'b110000001);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", get_out(1), 9'd0);
        st_req[1] = 1'b0;
        #1;
        rst = 1'b0;
        n_st = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (st_done[1]) n_st++;
        end
        check_int("rst_no_st_done", n_st, 0);
        check("rst_idle_after", get_out(1), 9'd0);

        // Fetch request held high across three back-to-back transactions.
        do_reset();
        got_mask  = '0;
        exp_mask  = '0;
        exp_mask[3]  = 1'b1;
        exp_mask[8]  = 1'b1;
        exp_mask[13] = 1'b1;
        n_irw     = 0;
        if_req[0] = 1'b1;
        for (int e = 0; e < 15; e++) begin
            step();
            if (if_done[0]) got_mask[e] = 1'b1;
            if (ir_w[0]) n_irw++;
        end
        if_req[0] = 1'b0;
        repeat (3) begin
            step();
            if (ir_w[0]) n_irw++;
        end
        check_int("cont_fetch_done_edges", int'(got_mask), int'(exp_mask));
        check_int("cont_fetch_ir_w_count", n_irw, 3);

        // Load latency on each instance.
        for (int g = 0; g < ND; g++) begin
            do_reset();
            lat = -1;
            ld_req[g] = 1'b1;
            for (int c = 0; c < 20 && lat < 0; c++) begin
                step();
                if (ld_done[g]) lat = c;
            end
            ld_req[g] = 1'b0;
            check_int($sformatf("sweep_lat_dut%0d", g), lat, rl_of(g));
            step();
        end

        // Randomized requesters on all instances.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int g = 0; g < ND; g++) model_edge(g, m_exp[g]);
            step();
            for (int g = 0; g < ND; g++) begin
                check($sformatf("rand_dut%0d_cyc%0d", g, c), get_out(g), m_exp[g]);
                drive_req(g, m_exp[g]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
